// File: rtl/image_link_pkg.sv
// Shared constants and types for the image-sender receive link.
package image_link_pkg;

    localparam int          NUM_PIXELS  = 76800;
    localparam logic [11:0] START_PIXEL = 12'h00A;
    localparam logic [7:0]  MARK_HI     = {4'b0000, START_PIXEL[11:8]};
    localparam logic [7:0]  MARK_LO     = START_PIXEL[7:0];

    typedef logic [11:0] pixel_t;

    typedef enum logic [1:0] {
        HUNT_HI,
        SYNC_LO,
        PIX_HI,
        PIX_LO
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/image_receiver_uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampler, byte/error strobes.
module uart_rx
    import image_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          rx_s, rx_prev;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value
    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s && rx_prev) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    valid_d = rx_s;
                    err_d   = !rx_s;
                    state_d = RX_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            sync_q  <= 3'b111;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], rx};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign byte_err   = err_q;

endmodule

// File: rtl/image_receiver.sv
// Image link receiver: UART bytes -> RGB444 pixels -> frame-buffer writes.
module image_receiver #(
    parameter int NUM_PIXELS     = image_link_pkg::NUM_PIXELS,
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_in,
    output logic [11:0]                   pixel,
    output logic [$clog2(NUM_PIXELS)-1:0] address,
    output logic                          pixel_valid,
    output logic                          image_ready,
    output logic                          frame_error,
    output logic                          busy
);
    import image_link_pkg::*;

    localparam int            CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int            AW           = $clog2(NUM_PIXELS);
    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] ADDR_LAST    = AW'(NUM_PIXELS - 1);
    localparam logic [TW-1:0] IDLE_LAST    = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (uart_in),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    state_e        state_q, state_d;
    logic [3:0]    hi_q, hi_d;
    pixel_t        pix_q, pix_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          wr_q, wr_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        pix_d   = pix_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        ready_d = ready_q;
        err_d   = err_q;
        idle_d  = (state_q == HUNT_HI || byte_valid) ? '0 : idle_q + 1'b1;
        if (byte_err) begin
            err_d   = 1'b1;
            state_d = HUNT_HI;
        end else if (state_q != HUNT_HI && !byte_valid && idle_q == IDLE_LAST) begin
            err_d   = 1'b1;
            state_d = HUNT_HI;
        end else if (byte_valid) begin
            unique case (state_q)
                HUNT_HI: begin
                    if (byte_data == MARK_HI) state_d = SYNC_LO;
                end
                SYNC_LO: begin
                    if (byte_data == MARK_LO) begin
                        state_d = PIX_HI;
                        cnt_d   = '0;
                        addr_d  = '0;
                        ready_d = 1'b0;
                        err_d   = 1'b0;
                    end else if (byte_data != MARK_HI) begin
                        state_d = HUNT_HI;
                    end
                end
                PIX_HI: begin
                    hi_d    = byte_data[3:0];
                    state_d = PIX_LO;
                end
                PIX_LO: begin
                    pix_d  = {hi_q, byte_data};
                    addr_d = cnt_q;
                    wr_d   = 1'b1;
                    // the final pixel closes the frame instead of advancing
                    if (cnt_q == ADDR_LAST) begin
                        ready_d = 1'b1;
                        state_d = HUNT_HI;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = PIX_HI;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT_HI;
            hi_q    <= '0;
            pix_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            idle_q  <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            pix_q   <= pix_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            idle_q  <= idle_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign pixel       = pix_q;
    assign address     = addr_q;
    assign pixel_valid = wr_q;
    assign image_ready = ready_q;
    assign frame_error = err_q;
    assign busy        = (state_q != HUNT_HI);

endmodule

// File: tb/tb_image_receiver.sv
// Directed bench for image_receiver: 4-pixel frames at 16 clks per bit.
module tb_image_receiver;

    localparam int NPIX = 4;
    localparam int CPB  = 16;
    localparam int TO   = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_in = 1'b1;
    logic [11:0] pixel;
    logic [1:0]  address;
    logic        pixel_valid;
    logic        image_ready;
    logic        frame_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_pix[$];
    logic [1:0]  wr_addr[$];

    image_receiver #(
        .NUM_PIXELS    (NPIX),
        .CLK_FREQ      (1600000),
        .BAUD_RATE     (100000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .pixel      (pixel),
        .address    (address),
        .pixel_valid(pixel_valid),
        .image_ready(image_ready),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pixel_valid) begin
            wr_pix.push_back(pixel);
            wr_addr.push_back(address);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        uart_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_in = stop_ok;
        repeat (CPB) @(posedge clk);
        uart_in = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_px(input logic [11:0] p);
        send_byte({4'h0, p[11:8]});
        send_byte(p[7:0]);
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", pixel_valid, 0);
        chk("rst_ready", image_ready, 0);
        chk("rst_err", frame_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", address, 0);
        chk("rst_pix", pixel, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // 1: basic frame
        wr_pix.delete(); wr_addr.delete();
        send_byte(8'h00); send_byte(8'h0A);
        send_px(12'hF00); send_px(12'h0F0); send_px(12'h00F);
        settle();
        chk("t1_ready_early", image_ready, 0);
        send_px(12'hABC);
        settle();
        chk("t1_nwr", wr_pix.size(), 4);
        if (wr_pix.size() == 4) begin
            chk("t1_p0", wr_pix[0], 12'hF00); chk("t1_a0", wr_addr[0], 0);
            chk("t1_p1", wr_pix[1], 12'h0F0); chk("t1_a1", wr_addr[1], 1);
            chk("t1_p2", wr_pix[2], 12'h00F); chk("t1_a2", wr_addr[2], 2);
            chk("t1_p3", wr_pix[3], 12'hABC); chk("t1_a3", wr_addr[3], 3);
        end
        chk("t1_ready", image_ready, 1);
        chk("t1_busy", busy, 0);

        // 2: junk then repeated 00 resync
        wr_pix.delete(); wr_addr.delete();
        send_byte(8'h55); send_byte(8'h00); send_byte(8'h00);
        settle();
        chk("t2_ready_hold", image_ready, 1);
        chk("t2_busy_sync", busy, 1);
        send_byte(8'h0A);
        settle();
        chk("t2_ready_drop", image_ready, 0);
        send_px(12'h123); send_px(12'h456); send_px(12'h789); send_px(12'hABC);
        settle();
        chk("t2_nwr", wr_pix.size(), 4);
        if (wr_pix.size() == 4) begin
            chk("t2_p0", wr_pix[0], 12'h123); chk("t2_a0", wr_addr[0], 0);
            chk("t2_p3", wr_pix[3], 12'hABC); chk("t2_a3", wr_addr[3], 3);
        end
        chk("t2_ready", image_ready, 1);

        // 3: stop-bit error on low byte of pixel 2
        wr_pix.delete(); wr_addr.delete();
        send_byte(8'h00); send_byte(8'h0A);
        send_px(12'h111);
        send_byte(8'h02); send_byte(8'h22, 1'b0);
        settle();
        chk("t3_err", frame_error, 1);
        chk("t3_busy", busy, 0);
        chk("t3_nwr", wr_pix.size(), 1);
        chk("t3_addr_hold", address, 0);
        send_byte(8'h00); send_byte(8'h0A);
        settle();
        chk("t3_err_clr", frame_error, 0);
        chk("t3_busy2", busy, 1);
        send_px(12'h321); send_px(12'h654); send_px(12'h987); send_px(12'hCBA);
        settle();
        chk("t3_nwr2", wr_pix.size(), 5);
        if (wr_pix.size() == 5) begin
            chk("t3_p1", wr_pix[1], 12'h321); chk("t3_a1", wr_addr[1], 0);
            chk("t3_a4", wr_addr[4], 3);
        end

        // 4: timeout after one pixel
        wr_pix.delete(); wr_addr.delete();
        send_byte(8'h00); send_byte(8'h0A);
        send_px(12'hCDE);
        repeat (TO / 2) @(posedge clk);
        #1;
        chk("t4_no_err_yet", frame_error, 0);
        chk("t4_busy_wait", busy, 1);
        repeat (TO / 2 + 100) @(posedge clk);
        #1;
        chk("t4_err", frame_error, 1);
        chk("t4_ready", image_ready, 0);
        chk("t4_busy", busy, 0);
        send_px(12'h123);
        settle();
        chk("t4_nwr", wr_pix.size(), 1);
        if (wr_pix.size() == 1) begin
            chk("t4_p0", wr_pix[0], 12'hCDE);
        end

        // 5: reset mid-byte
        wr_pix.delete(); wr_addr.delete();
        send_byte(8'h00); send_byte(8'h0A);
        settle();
        chk("t5_busy_pre", busy, 1);
        chk("t5_pix_pre", pixel, 12'hCDE);
        uart_in = 1'b0;
        repeat (CPB * 3) @(posedge clk);
        rst = 1'b1;
        uart_in = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_pix", pixel, 0);
        chk("t5_err", frame_error, 0);
        chk("t5_valid", pixel_valid, 0);
        rst = 1'b0;
        repeat (CPB * 12) @(posedge clk);
        chk("t5_nwr_rst", wr_pix.size(), 0);
        send_byte(8'h00); send_byte(8'h0A);
        send_px(12'h0AA); send_px(12'h0BB); send_px(12'h0CC); send_px(12'h0DD);
        settle();
        chk("t5_nwr", wr_pix.size(), 4);
        if (wr_pix.size() == 4) begin
            chk("t5_p0", wr_pix[0], 12'h0AA); chk("t5_a0", wr_addr[0], 0);
            chk("t5_p3", wr_pix[3], 12'h0DD); chk("t5_a3", wr_addr[3], 3);
        end
        chk("t5_ready", image_ready, 1);

        // 6: 2-clk glitch while waiting for the marker low byte
        wr_pix.delete(); wr_addr.delete();
        send_byte(8'h00);
        settle();
        uart_in = 1'b0;
        repeat (2) @(posedge clk);
        uart_in = 1'b1;
        repeat (CPB * 12) @(posedge clk);
        #1;
        chk("t6_busy", busy, 1);
        chk("t6_ready", image_ready, 1);
        chk("t6_err", frame_error, 0);
        send_byte(8'h0A);
        send_px(12'h5A5);
        settle();
        chk("t6_ready_drop", image_ready, 0);
        chk("t6_nwr", wr_pix.size(), 1);
        if (wr_pix.size() == 1) begin
            chk("t6_p0", wr_pix[0], 12'h5A5); chk("t6_a0", wr_addr[0], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
